io_int_arbiter: RTL and testbench
=================================

Name: io_int_arbiter

Overview:
- Interrupt controller that shares the single MIPS interrupt line among several asynchronous I/O event sources: Rojobot update (75 Hz), button/switch change, timer tick, and spare.
- Each source is synchronised into the clk50 domain, edge-detected, and latched as pending.
- One masked pending source is presented at a time on IO_INT_REQ/IO_INT_ID. The serviced bit is cleared via the IO_INT_ACK handshake.
- Replaces the per-source handshake flip-flops.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of IO_INT_ID; must satisfy 2^ID_W >= NUM_SRC.
- SYNC_STAGES, 2, synchroniser flops per source (2..3).

Ports:
- clk50, input, 1, system clock (50 MHz); all state updates on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- src_in, input, NUM_SRC, raw event inputs from any domain; a rising edge is one event.
- int_mask, input, NUM_SRC, 1 = source masked (still latched as pending, never selected).
- IO_INT_ACK, input, 1, level acknowledge from the MIPS interrupt handler.
- overrun_clr, input, NUM_SRC, per-bit clear strobe for overrun.
- IO_INT_REQ, output, 1, registered interrupt request to the CPU.
- IO_INT_ID, output, ID_W, index of the source being requested; valid while IO_INT_REQ=1.
- pending, output, NUM_SRC, registered pending flags.
- overrun, output, NUM_SRC, sticky flag: an event arrived while that source was already pending.

Behaviour:
- Reset (async, active-high):
  - Outputs: IO_INT_REQ=0, IO_INT_ID=0, pending=0, overrun=0.
  - Internal: synchroniser and edge-history flops=0, state=IDLE.
  - A source already high at reset release produces one event.
- Synchroniser: SYNC_STAGES-flop chain per source.
  - event[i] = sync_out[i] & ~sync_prev[i], combinational, one cycle wide.
- Pending register:
  - event[i] sets pending[i] on the next edge.
  - event[i] while pending[i]=1 sets overrun[i]; pending stays 1 (events are not counted).
  - Clearing pending[i] by ack in the same cycle as event[i]: set wins, and overrun is not set.
- Overrun register:
  - overrun_clr[i]=1 clears overrun[i].
  - Simultaneous set and clear: set wins.
- Selection:
  - eligible = pending & ~int_mask.
  - Without the optional feature, the lowest eligible index wins.
- State machine (registered outputs):
  - IDLE: if eligible != 0, latch IO_INT_ID = selected index, set IO_INT_REQ=1, go to REQ. Otherwise stay.
  - REQ:
    - IO_INT_REQ and IO_INT_ID are held stable.
    - A mask change or new events do not change IO_INT_ID or withdraw the request.
    - On IO_INT_ACK=1: clear pending[IO_INT_ID], drive IO_INT_REQ=0, go to ACKWAIT.
  - ACKWAIT: stay while IO_INT_ACK=1. When IO_INT_ACK=0, go to IDLE.
    - Guarantees one clear per ack, so a level ack spanning many cycles is safe.
  - IO_INT_ACK while in IDLE is ignored.
- Latency:
  - src_in rising, first sampled at edge k, gives IO_INT_REQ=1 after edge k+SYNC_STAGES+1.
  - That is, visible SYNC_STAGES+2 cycles after the sampling edge, from IDLE.
  - Back-to-back service: ACK low seen in ACKWAIT -> IDLE on the next edge -> REQ one edge later.
  - Minimum gap between requests: 2 cycles with IO_INT_REQ=0.
- Widths: if NUM_SRC < 2^ID_W, unused IDs are never emitted.

Optional Feature:
- INT_RR_EN defined: round-robin selection.
  - Search starts at (last_granted_id+1) mod NUM_SRC, wrapping.
  - last_granted_id is a register, reset to NUM_SRC-1, so the first grant favours index 0.
  - It updates on entry to REQ.
- INT_RR_EN undefined: fixed priority, lowest index wins, and there is no last_granted register.

Test Plan:
- Reset, then pulse src_in[0] for 3 cycles -> IO_INT_REQ=1, IO_INT_ID=0 exactly 4 cycles after the first sampling edge (SYNC_STAGES=2). Hold IO_INT_ACK=1 for 10 cycles -> pending[0] clears once, REQ=0. Release ack -> back to IDLE, no re-request.
- src_in[1] and src_in[3] rise together:
  - Without INT_RR_EN: ID=1 serviced first, then ID=3 two cycles after ack low.
  - With INT_RR_EN and last grant=1: ID=3 first.
- int_mask=4'b0100, src_in[2] rises -> pending[2]=1, IO_INT_REQ stays 0. Clear the mask -> request ID=2 on the next cycle after IDLE sees it.
- Second rising edge on src_in[0] while pending[0]=1 -> overrun[0]=1, still a single request. Assert overrun_clr[0] in the same cycle as a new overrun event -> overrun[0] stays 1.
- Event on src_in[2] synchronised in the same cycle IO_INT_ACK clears pending[2] -> pending[2]=1, overrun[2]=0, and a new request for ID=2 follows.
- Assert reset mid-REQ -> IO_INT_REQ, pending and overrun go to 0 immediately (async). A src_in held high through reset release produces exactly one new request.

Source files
------------

// File: rtl/io_int_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : io_int_arbiter
//  Purpose  : Shares the single MIPS interrupt line among NUM_SRC asynchronous
//             event sources. Each source is synchronised to clk50, then
//             rising-edge detected and latched as pending. One unmasked
//             pending source at a time is presented on IO_INT_REQ/IO_INT_ID
//             and cleared through a level IO_INT_ACK handshake.
//  Options  : INT_RR_EN - when defined, selection is round-robin starting
//             after the last granted index; otherwise lowest index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module io_int_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  src_in,
    input  logic [NUM_SRC-1:0]  int_mask,
    input  logic                IO_INT_ACK,
    input  logic [NUM_SRC-1:0]  overrun_clr,
    output logic                IO_INT_REQ,
    output logic [ID_W-1:0]     IO_INT_ID,
    output logic [NUM_SRC-1:0]  pending,
    output logic [NUM_SRC-1:0]  overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACKWAIT = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_sync_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_overrun;
    state_t             r_state;
    logic               r_req;
    logic [ID_W-1:0]    r_id;

    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_ovr_set;
    logic [NUM_SRC-1:0] w_overrun_nxt;
    logic [NUM_SRC-1:0] w_eligible;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_sel_vld;
    state_t             w_state_nxt;
    logic               w_req_nxt;
    logic [ID_W-1:0]    w_id_nxt;

    // Synchroniser chain plus one history stage for edge detection.
    // Flops clear to 0, so a source high at reset release yields one event.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_sync_prev <= '0;
        end else begin
            r_sync[0] <= src_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_event    = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_eligible = r_pending & ~int_mask;

    // Only the acknowledge of an outstanding request clears a pending bit.
    assign w_clr = (r_state == ST_REQ && IO_INT_ACK)
                 ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_id)
                 : '0;

    // A new event beats a simultaneous clear; such a collision is a fresh
    // event rather than an overrun, because the old one was just serviced.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_event;
    assign w_ovr_set     = w_event & r_pending & ~w_clr;
    assign w_overrun_nxt = (r_overrun & ~overrun_clr) | w_ovr_set;

    // Pending and sticky overrun flags.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

`ifdef INT_RR_EN
    logic [ID_W-1:0] r_last;
    int              w_rr_start;
    int              w_rr_idx;

    // Round-robin pick: scan from (r_last+1) mod NUM_SRC with wrap; the loop
    // runs backwards so the earliest index in search order is kept last.
    always_comb begin
        w_sel_id   = '0;
        w_sel_vld  = |w_eligible;
        w_rr_idx   = 0;
        w_rr_start = int'(r_last) + 1;
        if (w_rr_start >= NUM_SRC) begin
            w_rr_start = 0;
        end
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_rr_idx = w_rr_start + k;
            if (w_rr_idx >= NUM_SRC) begin
                w_rr_idx = w_rr_idx - NUM_SRC;
            end
            if (w_eligible[w_rr_idx]) begin
                w_sel_id = ID_W'(w_rr_idx);
            end
        end
    end

    // Remember the grant on entry to REQ; reset value makes index 0 first.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_last <= ID_W'(NUM_SRC - 1);
        end else if (r_state == ST_IDLE && w_sel_vld) begin
            r_last <= w_sel_id;
        end
    end
`else
    // Fixed priority pick: lowest eligible index wins.
    always_comb begin
        w_sel_id  = '0;
        w_sel_vld = |w_eligible;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end
`endif

    // Request state register with registered REQ/ID outputs.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // Next-state logic: ID is frozen outside IDLE, and ACKWAIT holds off
    // re-arming until the level ack drops so one ack clears one bit.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_id_nxt    = r_id;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_id_nxt    = w_sel_id;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (IO_INT_ACK) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_ACKWAIT;
                end
            end
            ST_ACKWAIT: begin
                if (!IO_INT_ACK) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign IO_INT_REQ = r_req;
    assign IO_INT_ID  = r_id;
    assign pending    = r_pending;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_io_int_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_int_arbiter
//  Purpose  : Directed testbench for io_int_arbiter (default build, fixed
//             priority). Cycle vectors from a table, then short hand-written
//             sequences for overrun, ack/event collision and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_int_arbiter;

    localparam int NUM_SRC     = 4;
    localparam int ID_W        = 2;
    localparam int SYNC_STAGES = 2;

    logic               clk50;
    logic               reset;
    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] int_mask;
    logic               IO_INT_ACK;
    logic [NUM_SRC-1:0] overrun_clr;
    logic               IO_INT_REQ;
    logic [ID_W-1:0]    IO_INT_ID;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] src;
        logic [3:0] mask;
        logic       ack;
        logic [3:0] oclr;
        int         reps;
        logic       req;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl[$];

    io_int_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .ID_W        (ID_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk50       (clk50),
        .reset       (reset),
        .src_in      (src_in),
        .int_mask    (int_mask),
        .IO_INT_ACK  (IO_INT_ACK),
        .overrun_clr (overrun_clr),
        .IO_INT_REQ  (IO_INT_REQ),
        .IO_INT_ID   (IO_INT_ID),
        .pending     (pending),
        .overrun     (overrun)
    );

    // 50 MHz clock
    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_st(input string nm, input logic req, input logic [1:0] id,
                          input logic [3:0] pend, input logic [3:0] ovr);
        chk({nm, ".req"}, 32'(IO_INT_REQ), 32'(req));
        if (req) chk({nm, ".id"}, 32'(IO_INT_ID), 32'(id));
        chk({nm, ".pend"}, 32'(pending), 32'(pend));
        chk({nm, ".ovr"}, 32'(overrun), 32'(ovr));
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic tick();
        @(posedge clk50);
        @(negedge clk50);
    endtask

    task automatic step(input logic [3:0] s, input logic a, input logic [3:0] oc);
        src_in      = s;
        int_mask    = 4'h0;
        IO_INT_ACK  = a;
        overrun_clr = oc;
        tick();
    endtask

    function automatic void add(input logic [3:0] s, input logic [3:0] m, input logic a,
                                input logic [3:0] oc, input int n, input logic rq,
                                input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
        vec_t v;
        v.src = s; v.mask = m; v.ack = a; v.oclr = oc; v.reps = n;
        v.req = rq; v.id = id; v.pend = p; v.ovr = o;
        tbl.push_back(v);
    endfunction

    initial begin
        // Each row: inputs for one edge (repeated reps times), then state after it.
        // src0 pulse: request 4 edges after the first sampling edge
        add(4'h1, 4'h0, 1'b0, 4'h0, 2,  1'b0, 2'd0, 4'h0, 4'h0);
        add(4'h1, 4'h0, 1'b0, 4'h0, 1,  1'b0, 2'd0, 4'h1, 4'h0);
        add(4'h0, 4'h0, 1'b0, 4'h0, 1,  1'b1, 2'd0, 4'h1, 4'h0);
        // long level ack: one clear, no re-request
        add(4'h0, 4'h0, 1'b1, 4'h0, 10, 1'b0, 2'd0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 1'b0, 4'h0, 4,  1'b0, 2'd0, 4'h0, 4'h0);
        // src1 and src3 together: 1 first, 3 after a 2-cycle gap
        add(4'hA, 4'h0, 1'b0, 4'h0, 2,  1'b0, 2'd0, 4'h0, 4'h0);
        add(4'hA, 4'h0, 1'b0, 4'h0, 1,  1'b0, 2'd0, 4'hA, 4'h0);
        add(4'hA, 4'h0, 1'b0, 4'h0, 1,  1'b1, 2'd1, 4'hA, 4'h0);
        add(4'hA, 4'h0, 1'b1, 4'h0, 1,  1'b0, 2'd0, 4'h8, 4'h0);
        add(4'hA, 4'h0, 1'b0, 4'h0, 1,  1'b0, 2'd0, 4'h8, 4'h0);
        add(4'hA, 4'h0, 1'b0, 4'h0, 1,  1'b1, 2'd3, 4'h8, 4'h0);
        add(4'hA, 4'h0, 1'b1, 4'h0, 1,  1'b0, 2'd0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 1'b0, 4'h0, 3,  1'b0, 2'd0, 4'h0, 4'h0);
        // masked src2 pends silently, request once mask drops
        add(4'h4, 4'h4, 1'b0, 4'h0, 2,  1'b0, 2'd0, 4'h0, 4'h0);
        add(4'h4, 4'h4, 1'b0, 4'h0, 4,  1'b0, 2'd0, 4'h4, 4'h0);
        add(4'h4, 4'h0, 1'b0, 4'h0, 1,  1'b1, 2'd2, 4'h4, 4'h0);
        add(4'h4, 4'h0, 1'b1, 4'h0, 1,  1'b0, 2'd0, 4'h0, 4'h0);
        add(4'h0, 4'h0, 1'b0, 4'h0, 3,  1'b0, 2'd0, 4'h0, 4'h0);

        reset       = 1'b1;
        src_in      = 4'h0;
        int_mask    = 4'h0;
        IO_INT_ACK  = 1'b0;
        overrun_clr = 4'h0;
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        reset = 1'b0;
        chk("reset.req",  32'(IO_INT_REQ), 32'd0);
        chk("reset.id",   32'(IO_INT_ID),  32'd0);
        chk("reset.pend", 32'(pending),    32'd0);
        chk("reset.ovr",  32'(overrun),    32'd0);

        // Table-driven part
        foreach (tbl[t]) begin
            for (int r = 0; r < tbl[t].reps; r++) begin
                src_in      = tbl[t].src;
                int_mask    = tbl[t].mask;
                IO_INT_ACK  = tbl[t].ack;
                overrun_clr = tbl[t].oclr;
                tick();
                exp_st($sformatf("vec%0d.%0d", t, r), tbl[t].req, tbl[t].id,
                       tbl[t].pend, tbl[t].ovr);
            end
        end

        // Overrun: second edge while pending, still a single request
        repeat (3) step(4'h1, 1'b0, 4'h0);
        exp_st("ovr.pend", 1'b0, 2'd0, 4'h1, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        exp_st("ovr.req", 1'b1, 2'd0, 4'h1, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        repeat (3) step(4'h1, 1'b0, 4'h0);
        exp_st("ovr.set", 1'b1, 2'd0, 4'h1, 4'h1);
        step(4'h0, 1'b1, 4'h0);
        exp_st("ovr.ack", 1'b0, 2'd0, 4'h0, 4'h1);
        repeat (2) step(4'h0, 1'b0, 4'h0);
        exp_st("ovr.single", 1'b0, 2'd0, 4'h0, 4'h1);

        // Overrun clear alone, then clear colliding with a new overrun
        step(4'h1, 1'b0, 4'h1);
        exp_st("oclr.clear", 1'b0, 2'd0, 4'h0, 4'h0);
        repeat (2) step(4'h1, 1'b0, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        exp_st("oclr.req", 1'b1, 2'd0, 4'h1, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        repeat (2) step(4'h1, 1'b0, 4'h0);
        step(4'h1, 1'b0, 4'h1);
        exp_st("oclr.setwins", 1'b1, 2'd0, 4'h1, 4'h1);
        step(4'h1, 1'b1, 4'h1);
        exp_st("oclr.clr2", 1'b0, 2'd0, 4'h0, 4'h0);
        repeat (3) step(4'h0, 1'b0, 4'h0);

        // New src2 event lands on the same edge as the ack clearing it
        repeat (3) step(4'h4, 1'b0, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        exp_st("coll.req", 1'b1, 2'd2, 4'h4, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        repeat (2) step(4'h4, 1'b0, 4'h0);
        step(4'h4, 1'b1, 4'h0);
        exp_st("coll.ack", 1'b0, 2'd0, 4'h4, 4'h0);
        step(4'h4, 1'b0, 4'h0);
        exp_st("coll.idle", 1'b0, 2'd0, 4'h4, 4'h0);
        step(4'h4, 1'b0, 4'h0);
        exp_st("coll.rereq", 1'b1, 2'd2, 4'h4, 4'h0);
        step(4'h0, 1'b1, 4'h0);
        exp_st("coll.done", 1'b0, 2'd0, 4'h0, 4'h0);
        repeat (3) step(4'h0, 1'b0, 4'h0);

        // Async reset while requesting with pending and overrun set
        repeat (3) step(4'h2, 1'b0, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        step(4'h0, 1'b0, 4'h0);
        repeat (3) step(4'h2, 1'b0, 4'h0);
        exp_st("prerst", 1'b1, 2'd1, 4'h2, 4'h2);
        #3 reset = 1'b1;
        #1;
        chk("arst.req",  32'(IO_INT_REQ), 32'd0);
        chk("arst.id",   32'(IO_INT_ID),  32'd0);
        chk("arst.pend", 32'(pending),    32'd0);
        chk("arst.ovr",  32'(overrun),    32'd0);
        @(negedge clk50);
        @(negedge clk50);
        reset = 1'b0;
        // src1 held high through release gives exactly one request
        repeat (3) step(4'h2, 1'b0, 4'h0);
        exp_st("rel.pend", 1'b0, 2'd0, 4'h2, 4'h0);
        step(4'h2, 1'b0, 4'h0);
        exp_st("rel.req", 1'b1, 2'd1, 4'h2, 4'h0);
        step(4'h2, 1'b1, 4'h0);
        exp_st("rel.ack", 1'b0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step(4'h2, 1'b0, 4'h0);
            exp_st($sformatf("rel.quiet%0d", i), 1'b0, 2'd0, 4'h0, 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
